// File: rtl/counter_mod_n_pkg.sv
// Shared definitions for the modulo-N counter: direction encodings and the
// per-edge operation decode used by the next-state mux.
package counter_mod_n_pkg;

  localparam logic CntDirUp = 1'b1;
  localparam logic CntDirDn = 1'b0;

  typedef enum logic [1:0] {
    OpHold,
    OpCount,
    OpLoad,
    OpClear
  } cnt_op_e;

  // Edge priority: clear > load > en > hold.
  function automatic cnt_op_e cnt_decode_op(input logic clear, input logic load, input logic en);
    cnt_op_e op;
    if (clear) begin
      op = OpClear;
    end else if (load) begin
      op = OpLoad;
    end else if (en) begin
      op = OpCount;
    end else begin
      op = OpHold;
    end
    return op;
  endfunction

endpackage

// File: rtl/counter_mod_n.sv
// Synchronous modulo-N up/down counter with enable, clamped parallel load and terminal-count
// cascade output. Define COUNTER_SAT_EN to saturate at the boundaries instead of wrapping.
module counter_mod_n
  import counter_mod_n_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned MODULUS   = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             zero
);

`ifdef COUNTER_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  // One spare bit so MODULUS = 2**WIDTH still has a representable maximum and compare.
  localparam logic [WIDTH:0]   MaxVal = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RstVal = WIDTH'(RESET_VAL);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("counter_mod_n: MODULUS out of range for WIDTH");
  end
  if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("counter_mod_n: RESET_VAL must be below MODULUS");
  end

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_load_ext;
  logic [WIDTH:0]   w_load_clamp;
  logic [WIDTH:0]   w_step;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_dir_up;
  cnt_op_e          w_op;
  logic             unused_top_bits;

  assign w_q_ext    = {1'b0, r_q};
  assign w_load_ext = {1'b0, load_val};
  assign w_at_max   = (w_q_ext == MaxVal);
  assign w_at_zero  = (r_q == '0);
  assign w_dir_up   = (up_dn == CntDirUp);
  assign w_op       = cnt_decode_op(clear, load, en);

  assign w_load_clamp = (w_load_ext > MaxVal) ? MaxVal : w_load_ext;

  always_comb begin
    w_step = w_q_ext;
    if (w_dir_up) begin
      if (w_at_max) begin
        w_step = SatEn ? w_q_ext : '0;
      end else begin
        w_step = w_q_ext + 1'b1;
      end
    end else begin
      if (w_at_zero) begin
        w_step = SatEn ? w_q_ext : MaxVal;
      end else begin
        w_step = w_q_ext - 1'b1;
      end
    end
  end

  always_comb begin
    w_q_next = r_q;
    unique case (w_op)
      OpClear: w_q_next = RstVal;
      OpLoad:  w_q_next = w_load_clamp[WIDTH-1:0];
      OpCount: w_q_next = w_step[WIDTH-1:0];
      default: w_q_next = r_q;
    endcase
  end

  always_ff @(posedge clock) begin
    r_q <= w_q_next;
  end

  // Spare bit is always zero for legal parameters.
  assign unused_top_bits = ^{w_step[WIDTH], w_load_clamp[WIDTH]};

  assign Q    = r_q;
  assign zero = w_at_zero;
  assign tc   = en & ~load & ~clear & (w_dir_up ? w_at_max : w_at_zero);

endmodule

// File: tb/tb_counter_mod_n.sv
// Directed self-checking bench for counter_mod_n: reset, wrap, load/clamp, priority,
// abort and a two-stage 0..59 countdown cascade.
module tb_counter_mod_n;
  import counter_mod_n_pkg::*;

`ifdef COUNTER_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Main stage, WIDTH=3 MODULUS=8
  logic       clear, en, up_dn, load;
  logic [2:0] load_val, q;
  logic       tc, zero;

  // Clamp stage, WIDTH=3 MODULUS=6
  logic       m_clear, m_load, m_en, m_up;
  logic [2:0] m_val, m_q;
  logic       m_tc, m_zero;

  // Cascade: units (MODULUS=10) feeds tens (MODULUS=6)
  logic       c_clear, c_load, c_en;
  logic [3:0] u_q;
  logic [2:0] t_q;
  logic       u_tc, t_tc, u_zero, t_zero;

  counter_mod_n #(.WIDTH(3), .MODULUS(8), .RESET_VAL(0)) u_dut (
    .clock(clk), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .Q(q), .tc(tc), .zero(zero)
  );

  counter_mod_n #(.WIDTH(3), .MODULUS(6), .RESET_VAL(0)) u_m6 (
    .clock(clk), .clear(m_clear), .en(m_en), .up_dn(m_up), .load(m_load),
    .load_val(m_val), .Q(m_q), .tc(m_tc), .zero(m_zero)
  );

  counter_mod_n #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_units (
    .clock(clk), .clear(c_clear), .en(c_en), .up_dn(CntDirDn), .load(c_load),
    .load_val(4'd9), .Q(u_q), .tc(u_tc), .zero(u_zero)
  );

  counter_mod_n #(.WIDTH(3), .MODULUS(6), .RESET_VAL(0)) u_tens (
    .clock(clk), .clear(c_clear), .en(u_tc), .up_dn(CntDirDn), .load(c_load),
    .load_val(3'd5), .Q(t_q), .tc(t_tc), .zero(t_zero)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int up_exp[9];
  int dn_exp[5];
  int prev;
  int exp_val;

  initial begin
    if (SatEn) begin
      up_exp = '{1, 2, 3, 4, 5, 6, 7, 7, 7};
      dn_exp = '{2, 1, 0, 0, 0};
    end else begin
      up_exp = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
      dn_exp = '{2, 1, 0, 7, 6};
    end

    clear = 1'b1; en = 1'b0; up_dn = CntDirUp; load = 1'b0; load_val = '0;
    m_clear = 1'b1; m_load = 1'b0; m_en = 1'b0; m_up = CntDirUp; m_val = '0;
    c_clear = 1'b1; c_load = 1'b0; c_en = 1'b0;

    // Reset
    tick();
    check_val("rst_q", q, 0);
    check_val("rst_zero", zero, 1);
    check_val("rst_tc", tc, 0);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("rst_hold%0d", i), q, 0);
    end
    check_val("rst_en_tc", tc, 0);
    clear = 1'b0; m_clear = 1'b0; c_clear = 1'b0;

    // Up wrap
    prev = 0;
    for (int i = 0; i < 9; i++) begin
      check_val($sformatf("up_tc%0d", i), tc, (prev == 7));
      tick();
      check_val($sformatf("up_q%0d", i), q, up_exp[i]);
      prev = up_exp[i];
    end

    // Down wrap from a loaded 3
    en = 1'b0; load = 1'b1; load_val = 3'd3;
    tick();
    check_val("ld3_q", q, 3);
    load = 1'b0; en = 1'b1; up_dn = CntDirDn;
    prev = 3;
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("dn_tc%0d", i), tc, (prev == 0));
      tick();
      check_val($sformatf("dn_q%0d", i), q, dn_exp[i]);
      prev = dn_exp[i];
    end

    // Load overrides en and masks tc
    load = 1'b1; load_val = 3'd5;
    #1;
    check_val("ld_en_tc", tc, 0);
    tick();
    check_val("ld5_q", q, 5);
    load = 1'b0; en = 1'b0;

    // Clamp on MODULUS=6
    m_load = 1'b1; m_val = 3'd7;
    tick();
    check_val("m6_clamp", m_q, 5);
    m_val = 3'd4;
    tick();
    check_val("m6_ld4", m_q, 4);
    m_load = 1'b0;

    // clear beats load
    clear = 1'b1; load = 1'b1; load_val = 3'd4;
    tick();
    check_val("clr_ld_q", q, 0);
    check_val("clr_ld_zero", zero, 1);
    clear = 1'b0; load = 1'b0;

    // Clear pulse mid-count aborts, counting resumes from 0
    en = 1'b1; up_dn = CntDirUp;
    repeat (5) tick();
    check_val("abort_pre", q, 5);
    check_val("abort_zero", zero, 0);
    clear = 1'b1;
    tick();
    check_val("abort_q", q, 0);
    clear = 1'b0;
    tick();
    check_val("resume1", q, 1);
    tick();
    check_val("resume2", q, 2);
    en = 1'b0;

    // Two-stage countdown 59 -> 00 -> 59 (or stops at 00 when saturating)
    c_load = 1'b1;
    tick();
    check_val("cas_ld", t_q * 10 + u_q, 59);
    c_load = 1'b0; c_en = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (k == 60) check_val("cas_tc00", t_tc, 1);
      tick();
      if (SatEn) exp_val = (k >= 59) ? 0 : 59 - k;
      else       exp_val = (k == 60) ? 59 : 59 - k;
      check_val($sformatf("cas_k%0d", k), t_q * 10 + u_q, exp_val);
    end
    check_val("cas_end_utc", u_tc, SatEn ? 1 : 0);
    check_val("cas_end_ttc", t_tc, SatEn ? 1 : 0);
    c_en = 1'b0;
    #1;
    check_val("cas_off_ttc", t_tc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
